// File: rtl/video_frame_source.sv
// AXI4-Stream raster test-pattern source: one pixel per beat, TLAST at end of
// line, TUSER on the first pixel of a frame, run/done control with optional back-to-back frames.
module video_frame_source #(
  parameter int DATA_WIDTH          = 32,
  parameter int CTRL_AXI_DATA_WIDTH = 32,
  parameter int CHECKER_SHIFT       = 3
) (
  input  logic                           axi_aclk,
  input  logic                           reset,
  input  logic                           run,
  input  logic                           continuous,
  input  logic [CTRL_AXI_DATA_WIDTH-1:0] src_width,
  input  logic [CTRL_AXI_DATA_WIDTH-1:0] src_heigth,
  input  logic [1:0]                     pattern,
  input  logic [DATA_WIDTH-1:0]          solid_color,
  output logic                           busy,
  output logic                           done,
  output logic [15:0]                    frame_count,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tuser
);

  localparam int CW = CTRL_AXI_DATA_WIDTH;
  localparam logic [0:0]    IDLE   = 1'b0;
  localparam logic [0:0]    STREAM = 1'b1;
  localparam logic [CW-1:0] ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ZERO   = {CW{1'b0}};

  function automatic logic [DATA_WIDTH-1:0] pixel(
    input logic [1:0]            pat,
    input logic [DATA_WIDTH-1:0] color,
    input logic [CW-1:0]         px,
    input logic [CW-1:0]         py
  );
    logic [DATA_WIDTH-1:0] result;
    case (pat)
      2'd0:    result = color;
      2'd1:    result = DATA_WIDTH'(px);
      2'd2:    result = DATA_WIDTH'(py);
      2'd3:    result = (px[CHECKER_SHIFT] ^ py[CHECKER_SHIFT]) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
      default: result = color;
    endcase
    return result;
  endfunction

  logic [0:0]            state_q, state_d;
  logic [CW-1:0]         x_q, x_d, y_q, y_d;
  logic [CW-1:0]         width_q, width_d, height_q, height_d;
  logic [1:0]            pattern_q, pattern_d;
  logic [DATA_WIDTH-1:0] color_q, color_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic                  done_q, done_d;
  logic [15:0]           frame_count_q, frame_count_d;

  logic                  xfer_s, eol_s, eof_s, size_ok_s, load_s;
  logic [CW-1:0]         nx_s, ny_s;

  // Next-state, coordinate and output-beat computation.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    width_d       = width_q;
    height_d      = height_q;
    pattern_d     = pattern_q;
    color_d       = color_q;
    tdata_d       = tdata_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    tuser_d       = tuser_q;
    done_d        = 1'b0;
    frame_count_d = frame_count_q;
    load_s        = 1'b0;

    xfer_s    = tvalid_q & m_axis_tready;
    eol_s     = (x_q == width_q - ONE);
    eof_s     = eol_s & (y_q == height_q - ONE);
    size_ok_s = (src_width != ZERO) && (src_heigth != ZERO);
    nx_s      = eol_s ? ZERO : x_q + ONE;
    ny_s      = eol_s ? y_q + ONE : y_q;

    case (state_q)
      IDLE: begin
        if (run) begin
          if (size_ok_s) begin
            load_s = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          load_s = 1'b0;
        end
      end
      STREAM: begin
        if (xfer_s) begin
          if (eof_s) begin
            done_d        = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            if (continuous && size_ok_s) begin
              load_s = 1'b1;
            end else begin
              state_d  = IDLE;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
              tuser_d  = 1'b0;
            end
          end else begin
            x_d     = nx_s;
            y_d     = ny_s;
            tdata_d = pixel(pattern_q, color_q, nx_s, ny_s);
            tlast_d = (nx_s == width_q - ONE);
            tuser_d = 1'b0;
          end
        end else begin
          tvalid_d = tvalid_q;
        end
      end
      default: begin
        state_d  = IDLE;
        tvalid_d = 1'b0;
      end
    endcase

    // A frame start latches config and presents pixel (0,0) on the next edge.
    if (load_s) begin
      state_d   = STREAM;
      width_d   = src_width;
      height_d  = src_heigth;
      pattern_d = pattern;
      color_d   = solid_color;
      x_d       = ZERO;
      y_d       = ZERO;
      tvalid_d  = 1'b1;
      tdata_d   = pixel(pattern, solid_color, ZERO, ZERO);
      tlast_d   = (src_width == ONE);
      tuser_d   = 1'b1;
    end else begin
      state_d = state_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      state_q       <= IDLE;
      x_q           <= ZERO;
      y_q           <= ZERO;
      width_q       <= ZERO;
      height_q      <= ZERO;
      pattern_q     <= 2'd0;
      color_q       <= {DATA_WIDTH{1'b0}};
      tdata_q       <= {DATA_WIDTH{1'b0}};
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tuser_q       <= 1'b0;
      done_q        <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      width_q       <= width_d;
      height_q      <= height_d;
      pattern_q     <= pattern_d;
      color_q       <= color_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      tuser_q       <= tuser_d;
      done_q        <= done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign busy          = (state_q == STREAM);
  assign done          = done_q;
  assign frame_count   = frame_count_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;

endmodule

// File: tb/tb_video_frame_source.sv
// Bench for video_frame_source: fixed probe vectors, a frame-level reference
// model for random frames, and hand sequences for reset, degenerate sizes and backpressure.
module tb_video_frame_source;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        continuous;
  logic [31:0] src_width;
  logic [31:0] src_heigth;
  logic [1:0]  pattern;
  logic [31:0] solid_color;
  logic        busy;
  logic        done;
  logic [15:0] frame_count;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_fc  = 16'd0;

  always #5 clk = ~clk;

  video_frame_source #(
    .DATA_WIDTH(32), .CTRL_AXI_DATA_WIDTH(32), .CHECKER_SHIFT(3)
  ) dut (
    .axi_aclk(clk), .reset(reset), .run(run), .continuous(continuous),
    .src_width(src_width), .src_heigth(src_heigth), .pattern(pattern),
    .solid_color(solid_color), .busy(busy), .done(done), .frame_count(frame_count),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser)
  );

  typedef struct { int w; int h; int pat; logic [31:0] color; } cfg_t;
  typedef struct { logic [31:0] data; logic last; logic user; logic eof; } beat_t;
  typedef struct {
    int w; int h; int pat; logic [31:0] color;
    int px; int py; logic [31:0] d; logic l; logic u; int n;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference pixel: squares of 8x8 alternate, starting dark at the origin.
  function automatic logic [31:0] ref_pixel(input cfg_t c, input int x, input int y);
    case (c.pat)
      0:       return c.color;
      1:       return 32'(x);
      2:       return 32'(y);
      default: return ((((x / 8) + (y / 8)) % 2) == 1) ? 32'hFFFF_FFFF : 32'h0;
    endcase
  endfunction

  task automatic apply_cfg(input cfg_t c);
    src_width   = 32'(c.w);
    src_heigth  = 32'(c.h);
    pattern     = 2'(c.pat);
    solid_color = c.color;
  endtask

  // Present the config of frame idx, or unrelated values if none follows.
  task automatic apply_next(input cfg_t frames[$], input int idx);
    if (idx < frames.size()) begin
      apply_cfg(frames[idx]);
    end else begin
      src_width   = $urandom;
      src_heigth  = $urandom;
      pattern     = 2'($urandom_range(0, 3));
      solid_color = $urandom;
    end
  endtask

  // Stream one or more back-to-back frames and check every cycle against the model.
  task automatic play(input cfg_t frames[$], input int ready_pct, input bit poke_run);
    beat_t q[$];
    beat_t b;
    int    fi = 0;
    int    cyc = 0;
    bit    eof_x;
    bit    done_exp = 1'b0;
    foreach (frames[f]) begin
      for (int y = 0; y < frames[f].h; y++) begin
        for (int x = 0; x < frames[f].w; x++) begin
          b.data = ref_pixel(frames[f], x, y);
          b.last = (x == frames[f].w - 1);
          b.user = (x == 0 && y == 0);
          b.eof  = (x == frames[f].w - 1 && y == frames[f].h - 1);
          q.push_back(b);
        end
      end
    end
    apply_cfg(frames[0]);
    continuous = (frames.size() > 1);
    run = 1'b1;
    tick();
    run = 1'b0;
    apply_next(frames, 1);
    while (1) begin
      chk("done", 64'(done), 64'(done_exp));
      done_exp = 1'b0;
      chk("frame_count", 64'(frame_count), 64'(exp_fc));
      if (q.size() == 0) break;
      if (cyc >= 5000) begin
        n_tests++;
        n_fail++;
        $display("FAIL play_timeout: got %0d beats left, expected 0", q.size());
        break;
      end
      chk("busy", 64'(busy), 64'd1);
      chk("tvalid", 64'(m_axis_tvalid), 64'd1);
      chk("tdata", 64'(m_axis_tdata), 64'(q[0].data));
      chk("tlast", 64'(m_axis_tlast), 64'(q[0].last));
      chk("tuser", 64'(m_axis_tuser), 64'(q[0].user));
      if (ready_pct < 0) m_axis_tready = ~m_axis_tready;
      else m_axis_tready = (int'($urandom_range(0, 99)) < ready_pct);
      run = poke_run ? 1'($urandom_range(0, 1)) : 1'b0;
      eof_x = 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        eof_x = q[0].eof;
        void'(q.pop_front());
      end
      tick();
      cyc++;
      run = 1'b0;
      if (eof_x) begin
        done_exp = 1'b1;
        exp_fc = exp_fc + 16'd1;
        fi++;
        continuous = (fi + 1 < frames.size());
        apply_next(frames, fi + 1);
      end
    end
    chk("idle_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    tick();
    chk("done_clear", 64'(done), 64'd0);
  endtask

  // Run one frame at full throughput and probe a single beat against a fixed record.
  task automatic run_vec(input vec_t v, input int idx);
    int          cnt = 0;
    int          cyc = 0;
    logic [31:0] d = 32'hx;
    logic        l = 1'bx;
    logic        u = 1'bx;
    cfg_t        c;
    c = '{v.w, v.h, v.pat, v.color};
    apply_cfg(c);
    continuous    = 1'b0;
    m_axis_tready = 1'b1;
    run           = 1'b1;
    tick();
    run = 1'b0;
    while (m_axis_tvalid && cyc < 1000) begin
      if (cnt == v.py * v.w + v.px) begin
        d = m_axis_tdata;
        l = m_axis_tlast;
        u = m_axis_tuser;
      end
      cnt++;
      tick();
      cyc++;
    end
    exp_fc = exp_fc + 16'd1;
    chk($sformatf("vec%0d_beats", idx), 64'(cnt), 64'(v.n));
    chk($sformatf("vec%0d_data", idx), 64'(d), 64'(v.d));
    chk($sformatf("vec%0d_last", idx), 64'(l), 64'(v.l));
    chk($sformatf("vec%0d_user", idx), 64'(u), 64'(v.u));
    chk($sformatf("vec%0d_done", idx), 64'(done), 64'd1);
    chk($sformatf("vec%0d_fc", idx), 64'(frame_count), 64'(exp_fc));
    tick();
    chk($sformatf("vec%0d_done_clear", idx), 64'(done), 64'd0);
  endtask

  initial begin
    vec_t vecs[12];
    cfg_t fr[$];
    cfg_t c;

    vecs[0]  = '{4, 2, 1, 32'h0, 0, 0, 32'h0, 1'b0, 1'b1, 8};
    vecs[1]  = '{4, 2, 1, 32'h0, 3, 0, 32'h3, 1'b1, 1'b0, 8};
    vecs[2]  = '{4, 2, 1, 32'h0, 2, 1, 32'h2, 1'b0, 1'b0, 8};
    vecs[3]  = '{4, 2, 1, 32'h0, 3, 1, 32'h3, 1'b1, 1'b0, 8};
    vecs[4]  = '{16, 16, 3, 32'h0, 7, 0, 32'h0, 1'b0, 1'b0, 256};
    vecs[5]  = '{16, 16, 3, 32'h0, 8, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 256};
    vecs[6]  = '{16, 16, 3, 32'h0, 8, 8, 32'h0, 1'b0, 1'b0, 256};
    vecs[7]  = '{16, 16, 3, 32'h0, 0, 8, 32'hFFFF_FFFF, 1'b0, 1'b0, 256};
    vecs[8]  = '{1, 3, 2, 32'h0, 0, 0, 32'h0, 1'b1, 1'b1, 3};
    vecs[9]  = '{1, 3, 2, 32'h0, 0, 2, 32'h2, 1'b1, 1'b0, 3};
    vecs[10] = '{3, 1, 0, 32'hDEAD_BEEF, 2, 0, 32'hDEAD_BEEF, 1'b1, 1'b0, 3};
    vecs[11] = '{5, 3, 2, 32'h0, 4, 2, 32'h2, 1'b1, 1'b0, 15};

    reset = 1'b1; run = 1'b0; continuous = 1'b0; m_axis_tready = 1'b0;
    src_width = 32'd0; src_heigth = 32'd0; pattern = 2'd0; solid_color = 32'h0;
    tick();
    tick();
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_tuser", 64'(m_axis_tuser), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fc", 64'(frame_count), 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Backpressure with alternating ready, then two back-to-back frames.
    m_axis_tready = 1'b1;
    fr = {};
    fr.push_back('{3, 1, 0, 32'hDEAD_BEEF});
    play(fr, -1, 1'b0);
    fr = {};
    fr.push_back('{2, 2, 1, 32'h0});
    fr.push_back('{2, 2, 2, 32'h0});
    play(fr, 100, 1'b0);

    // Zero-sized requests: done pulse only.
    for (int k = 0; k < 2; k++) begin
      c = (k == 0) ? '{0, 5, 1, 32'h0} : '{5, 0, 1, 32'h0};
      apply_cfg(c);
      run = 1'b1;
      tick();
      run = 1'b0;
      chk("zero_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("zero_done", 64'(done), 64'd1);
      chk("zero_busy", 64'(busy), 64'd0);
      chk("zero_fc", 64'(frame_count), 64'(exp_fc));
      tick();
      chk("zero_done_clear", 64'(done), 64'd0);
      chk("zero_tvalid2", 64'(m_axis_tvalid), 64'd0);
    end

    // Reset with a beat stalled, coinciding with a run request.
    c = '{8, 8, 1, 32'h0};
    apply_cfg(c);
    m_axis_tready = 1'b1;
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    m_axis_tready = 1'b0;
    tick();
    chk("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("stall_tdata", 64'(m_axis_tdata), 64'd2);
    reset = 1'b1;
    run   = 1'b1;
    tick();
    reset = 1'b0;
    run   = 1'b0;
    exp_fc = 16'd0;
    chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_fc", 64'(frame_count), 64'd0);
    tick();
    chk("post_rst_done", 64'(done), 64'd0);
    chk("post_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    fr = {};
    fr.push_back('{8, 2, 1, 32'h0});
    play(fr, 100, 1'b1);

    // Random frame groups with random backpressure and stray run pulses.
    for (int it = 0; it < 15; it++) begin
      fr = {};
      for (int f = 0; f < int'($urandom_range(1, 3)); f++) begin
        c.w     = int'($urandom_range(1, 12));
        c.h     = int'($urandom_range(1, 5));
        c.pat   = int'($urandom_range(0, 3));
        c.color = $urandom;
        fr.push_back(c);
      end
      play(fr, int'($urandom_range(25, 100)), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
